buffer_feed_sched: RTL and testbench
====================================

# buffer_feed_sched

Scheduler that owns the 4-lane accelerator address buffer. It arbitrates write traffic from two requesters (CPU bus slave, DMA) into the buffer and counts entries per lane. Once every lane holds DEPTH words, it drains the buffer into the accelerator in lockstep and starts the accelerator. It then waits for completion before accepting the next tile.

## Interface
- LANES, 4, number of buffer lanes (FIFOs)
- DEPTH, 4, words per lane per tile
- WIDTH, 32, data width
- BASE_ADDR, 0, byte address of lane 0; lane stride is DEPTH*4 bytes
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with BUF_SCHED_TIMEOUT_EN)
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- m0_req / m1_req  in  1  write request, CPU / DMA; held until granted
- m0_addr / m1_addr  in  32  byte address; bits [27:0] decoded
- m0_data / m1_data  in  WIDTH  write data
- m0_gnt / m1_gnt  out  1  combinational grant; request accepted on an edge where req && gnt
- buf_en_w  out  1  one-cycle write strobe to buffer
- buf_addr  out  32  registered address of the accepted write
- buf_data  out  WIDTH  registered data of the accepted write
- buf_en_r  out  1  lockstep read strobe to all lanes
- acc_start  out  1  one-cycle accelerator start pulse
- acc_done  in  1  accelerator completion pulse
- busy  out  1  high in DRAIN and WAIT_DONE
- addr_err  out  1  one-cycle pulse: accepted write was out of range or to a full lane, and was dropped
- tmo_err  out  1  sticky watchdog flag; cleared by reset or the next acc_start

## Operation
- FSM states: LOAD, DRAIN, WAIT_DONE.
- LOAD:
  - Grants are enabled.
  - lane = (addr[27:0] − BASE_ADDR) / (DEPTH*4).
  - Valid lane with count < DEPTH: forward the write and increment that lane's count.
  - Otherwise: drop the write and pulse addr_err.
- Arbitration:
  - Single requester: granted immediately.
  - Both requesting: round-robin. The pointer flips to the other master after each accepted grant. The pointer resets to m0.
- LOAD→DRAIN when all lane counts equal DEPTH. The check is evaluated on registered counts, so the transition happens the cycle after the last write is forwarded.
- DRAIN:
  - Grants are 0.
  - buf_en_r is high for exactly DEPTH consecutive cycles.
  - acc_start pulses in the first DRAIN cycle.
  - After DEPTH cycles, go to WAIT_DONE.
- WAIT_DONE:
  - Grants are 0.
  - On acc_done, clear all lane counts and go to LOAD.
- acc_done outside WAIT_DONE is ignored.
- Reset values: all outputs 0, counts 0, state LOAD, rr pointer m0.

## Timing
- Grant to buffer write: an accepting edge at cycle N gives buf_en_w/buf_addr/buf_data valid in cycle N+1. Peak throughput is one write per cycle.
- A requester must hold addr/data stable while req=1 and gnt=0.
- Tile latency, last write to acc_start: 2 cycles (count register, then DRAIN entry).
- acc_done is accepted in the cycle it is sampled. LOAD is entered on the next edge, and grants are available in that cycle.
- Reset mid-DRAIN or mid-WAIT_DONE:
  - Next edge returns to LOAD with all counts 0.
  - buf_en_r and acc_start deassert immediately after that edge.
- buf_en_w and buf_en_r are never high in the same cycle.

## Configuration
- BUF_SCHED_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_DONE.
  - Reaching TIMEOUT_CYCLES without acc_done sets tmo_err, clears counts and returns to LOAD.
- Not defined:
  - WAIT_DONE waits indefinitely.
  - tmo_err is tied to 0.
  - No counter is synthesized.

## Structure
- Package buf_sched_pkg holds:
  - state enum (LOAD, DRAIN, WAIT_DONE)
  - lane index width function clog2(LANES)
  - default LANE_STRIDE = DEPTH*4
- Sub-module rr_arb2: two-requester round-robin arbiter with accept input and registered pointer.
- Lane decode, counters, FSM and watchdog live in the top module.

## Test plan
- Single master fills the tile: m0 writes BASE+0..BASE+60 (16 words). Expect 16 buf_en_w pulses, then buf_en_r high 4 cycles and one acc_start 2 cycles after the last write.
- Contention: m0_req and m1_req held high for 4 cycles. Expect grants m0,m1,m0,m1, and buf_addr follows the same order.
- Bad writes: write to BASE+64 (out of range), then a 5th write to lane 0. Expect addr_err pulse each time, no buf_en_w, lane 0 count stays 4.
- Grant blocking: requests during DRAIN/WAIT_DONE see gnt=0. After acc_done, LOAD is entered and the first grant is issued in the next cycle.
- Reset mid-drain: rstn=0 in the 2nd DRAIN cycle. Next cycle buf_en_r=0, busy=0, and a fresh 16-word fill is needed before acc_start.
- Watchdog (with BUF_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=8): no acc_done. Expect tmo_err=1 and state LOAD after 8 WAIT_DONE cycles; the next acc_start clears tmo_err.

Source files
------------

// File: rtl/buffer_feed_sched_pkg.sv
// Shared types and sizing helpers for the accelerator address-buffer scheduler.
package buf_sched_pkg;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    DRAIN     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH = 4;
  localparam int LANE_STRIDE   = DEFAULT_DEPTH * 4;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buffer_feed_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer favours the master that was not granted last.
module rr_arb2 (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic gnt0,
  output logic gnt1
);

  logic ptr;

  assign gnt0 = en & req0 & (~req1 | ~ptr);
  assign gnt1 = en & req1 & (~req0 | ptr);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= gnt0;
    end
  end

endmodule

// File: rtl/buffer_feed_sched.sv
// Fills a LANES x DEPTH address buffer from CPU/DMA writes, drains it in lockstep and starts the accelerator.
// Optional watchdog in WAIT_DONE is enabled by defining BUF_SCHED_TIMEOUT_EN.
module buffer_feed_sched
  import buf_sched_pkg::*;
#(
  parameter int          LANES          = 4,
  parameter int          DEPTH          = 4,
  parameter int          WIDTH          = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             m0_req,
  input  logic [31:0]      m0_addr,
  input  logic [WIDTH-1:0] m0_data,
  output logic             m0_gnt,
  input  logic             m1_req,
  input  logic [31:0]      m1_addr,
  input  logic [WIDTH-1:0] m1_data,
  output logic             m1_gnt,
  output logic             buf_en_w,
  output logic [31:0]      buf_addr,
  output logic [WIDTH-1:0] buf_data,
  output logic             buf_en_r,
  output logic             acc_start,
  input  logic             acc_done,
  output logic             busy,
  output logic             addr_err,
  output logic             tmo_err
);

  localparam int STRIDE = (DEPTH == DEFAULT_DEPTH) ? LANE_STRIDE : DEPTH * 4;
  localparam int LW     = idx_w(LANES);
  localparam int CW     = idx_w(DEPTH + 1);
  localparam int DW     = idx_w(DEPTH);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt [LANES];
  logic [DW-1:0]     dcnt;
  logic              clr_cnt;
  logic              all_full;
  logic              accept;
  logic [31:0]       sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic [27:0]       offset;
  logic              in_range;
  logic [LW-1:0]     lane;
  logic              wr_ok;
  logic              vld_p1, err_p1;
  logic [31:0]       addr_p1;
  logic [WIDTH-1:0]  data_p1;

`ifdef BUF_SCHED_TIMEOUT_EN
  localparam int TW = idx_w(TIMEOUT_CYCLES);
  logic [TW-1:0]     wd_cnt;
  logic              tmo_hit;
  logic              tmo_q;
`endif

  rr_arb2 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .en     (state == LOAD),
    .req0   (m0_req),
    .req1   (m1_req),
    .accept (accept),
    .gnt0   (m0_gnt),
    .gnt1   (m1_gnt)
  );

  // p0: grant, lane decode and room check on the selected request
  assign accept   = (m0_req & m0_gnt) | (m1_req & m1_gnt);
  assign sel_addr = m1_gnt ? m1_addr : m0_addr;
  assign sel_data = m1_gnt ? m1_data : m0_data;
  assign offset   = sel_addr[27:0] - BASE_ADDR[27:0];
  assign in_range = offset < 28'(LANES * STRIDE);
  assign lane     = LW'(offset / 28'(STRIDE));
  assign wr_ok    = accept & in_range & (cnt[lane] < CW'(DEPTH));

  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (cnt[i] != CW'(DEPTH)) all_full = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr_cnt) begin
      for (int i = 0; i < LANES; i++) cnt[i] <= '0;
    end else if (wr_ok) begin
      cnt[lane] <= cnt[lane] + 1'b1;
    end
  end

  // p1: registered buffer write port and drop indication
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= wr_ok;
      err_p1 <= accept & ~wr_ok;
      if (wr_ok) begin
        addr_p1 <= sel_addr;
        data_p1 <= sel_data;
      end
    end
  end

  assign buf_en_w = vld_p1;
  assign buf_addr = addr_p1;
  assign buf_data = data_p1;
  assign addr_err = err_p1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
`ifdef BUF_SCHED_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    case (state)
      LOAD: begin
        if (all_full) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (dcnt == DW'(DEPTH - 1)) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (acc_done) begin
          state_nxt = LOAD;
          clr_cnt   = 1'b1;
        end
`ifdef BUF_SCHED_TIMEOUT_EN
        else if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = LOAD;
          clr_cnt   = 1'b1;
          tmo_hit   = 1'b1;
        end
`endif
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dcnt <= '0;
    end else if (state == DRAIN) begin
      dcnt <= dcnt + 1'b1;
    end else begin
      dcnt <= '0;
    end
  end

  assign buf_en_r  = (state == DRAIN);
  assign acc_start = (state == DRAIN) && (dcnt == '0);
  assign busy      = (state != LOAD);

`ifdef BUF_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_cnt <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT_DONE) ? wd_cnt + 1'b1 : '0;
      if (tmo_hit) begin
        tmo_q <= 1'b1;
      end else if (acc_start) begin
        tmo_q <= 1'b0;
      end
    end
  end

  assign tmo_err = tmo_q;
`else
  localparam int tmo_cycles_unused = TIMEOUT_CYCLES;
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_feed_sched.sv
// Directed self-checking bench for buffer_feed_sched; define BUF_SCHED_TIMEOUT_EN to cover the watchdog.
module tb_buffer_feed_sched;

`ifdef BUF_SCHED_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic        clk, rstn;
  logic        m0_req, m1_req, m0_gnt, m1_gnt;
  logic [31:0] m0_addr, m1_addr, m0_data, m1_data;
  logic        buf_en_w, buf_en_r, acc_start, acc_done, busy, addr_err, tmo_err;
  logic [31:0] buf_addr, buf_data;

  int total = 0;
  int bad   = 0;
  int nw = 0, nr = 0, ns = 0, ovl = 0;

  buffer_feed_sched #(
    .LANES(4), .DEPTH(4), .WIDTH(32), .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_data(m0_data), .m0_gnt(m0_gnt),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_data(m1_data), .m1_gnt(m1_gnt),
    .buf_en_w(buf_en_w), .buf_addr(buf_addr), .buf_data(buf_data),
    .buf_en_r(buf_en_r), .acc_start(acc_start), .acc_done(acc_done),
    .busy(busy), .addr_err(addr_err), .tmo_err(tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (buf_en_w) nw++;
    if (buf_en_r) nr++;
    if (acc_start) ns++;
    if (buf_en_w && buf_en_r) ovl++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge; one accepted write per call.
  task automatic wr(input int m, input logic [31:0] a, input logic [31:0] d, input logic exp_ok);
    int n = 0;
    if (m == 0) begin m0_req = 1'b1; m0_addr = a; m0_data = d; end
    else        begin m1_req = 1'b1; m1_addr = a; m1_data = d; end
    #1;
    while (!((m == 0) ? m0_gnt : m1_gnt) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("wr_gnt", (m == 0) ? m0_gnt : m1_gnt, 1);
    @(posedge clk);
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("wr_en_w", buf_en_w, exp_ok);
    chk("wr_addr_err", addr_err, !exp_ok);
    if (exp_ok) begin
      chk("wr_buf_addr", buf_addr, a);
      chk("wr_buf_data", buf_data, d);
    end
  endtask

  task automatic fill(input bit skip_last);
    for (int l = 0; l < 4; l++) begin
      for (int w = 0; w < 4; w++) begin
        if (!(skip_last && l == 3 && w == 3))
          wr(l % 2, 32'(l * 16 + w * 4), 32'hA000 + 32'(l * 4 + w), 1'b1);
      end
    end
  endtask

  // Starts on the falling edge of the last forwarded write; ends in the first WAIT_DONE cycle.
  task automatic check_drain(input bit pulse_done);
    @(negedge clk);
    chk("drain_start", acc_start, 1);
    chk("drain_en_r0", buf_en_r, 1);
    chk("drain_busy0", busy, 1);
    chk("drain_no_w", buf_en_w, 0);
    if (pulse_done) acc_done = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      acc_done = 1'b0;
      chk("drain_en_r", buf_en_r, 1);
      chk("drain_start_once", acc_start, 0);
    end
    @(negedge clk);
    chk("wait_en_r", buf_en_r, 0);
    chk("wait_busy", busy, 1);
  endtask

  initial begin
    rstn = 1'b0; acc_done = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_data = '0; m1_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_en_w", buf_en_w, 0);
    chk("rst_en_r", buf_en_r, 0);
    chk("rst_start", acc_start, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_tmo", tmo_err, 0);
    chk("rst_buf_addr", buf_addr, 0);
    chk("rst_buf_data", buf_data, 0);
    rstn = 1'b1;

    // Tile 1: full fill, drain, hold in WAIT_DONE
    fill(1'b0);
    #1;
    chk("tile1_nw", nw, 16);
    chk("tile1_no_start_yet", acc_start, 0);
    check_drain(1'b0);
    #1;
    chk("tile1_nr", nr, 4);
    chk("tile1_ns", ns, 1);

    // Grants blocked in WAIT_DONE, released right after acc_done
    m0_addr = 32'd0; m0_data = 32'h55; m0_req = 1'b1;
    m1_addr = 32'd16; m1_req = 1'b1;
    #1;
    chk("wait_gnt0", m0_gnt, 0);
    chk("wait_gnt1", m1_gnt, 0);
    m1_req = 1'b0;
    @(negedge clk);
    acc_done = 1'b1;
    #1;
    chk("done_cycle_busy", busy, 1);
    chk("done_cycle_gnt0", m0_gnt, 0);
    @(negedge clk);
    acc_done = 1'b0;
    #1;
    chk("after_done_busy", busy, 0);
    chk("after_done_gnt0", m0_gnt, 1);
    @(negedge clk);
    m0_req = 1'b0;
    chk("after_done_en_w", buf_en_w, 1);
    chk("after_done_addr", buf_addr, 0);
    wr(1, 32'd16, 32'h66, 1'b1);

    // Contention: alternating grants starting at m0
    m0_req = 1'b1; m0_addr = 32'd32; m0_data = 32'd32;
    m1_req = 1'b1; m1_addr = 32'd48; m1_data = 32'd48;
    #1;
    chk("rr0_g0", m0_gnt, 1);
    chk("rr0_g1", m1_gnt, 0);
    @(negedge clk);
    m0_addr = 32'd36; m0_data = 32'd36;
    #1;
    chk("rr1_g1", m1_gnt, 1);
    chk("rr1_addr", buf_addr, 32);
    @(negedge clk);
    m1_addr = 32'd52; m1_data = 32'd52;
    #1;
    chk("rr2_g0", m0_gnt, 1);
    chk("rr2_addr", buf_addr, 48);
    @(negedge clk);
    m0_addr = 32'd40; m0_data = 32'd40;
    #1;
    chk("rr3_g1", m1_gnt, 1);
    chk("rr3_addr", buf_addr, 36);
    chk("rr3_data", buf_data, 36);
    @(negedge clk);
    m1_req = 1'b0;
    #1;
    chk("rr4_g0", m0_gnt, 1);
    chk("rr4_addr", buf_addr, 52);
    @(negedge clk);
    m0_req = 1'b0;
    chk("rr5_addr", buf_addr, 40);
    chk("rr5_en_w", buf_en_w, 1);

    // Dropped writes and the rest of tile 2
    wr(0, 32'd64, 32'h1, 1'b0);
    wr(0, 32'd4,  32'h2, 1'b1);
    wr(0, 32'd8,  32'h3, 1'b1);
    wr(0, 32'd12, 32'h4, 1'b1);
    wr(0, 32'd0,  32'h5, 1'b0);
    chk("lane0_full_busy", busy, 0);
    wr(1, 32'hF000_0014, 32'h6, 1'b1);
    wr(1, 32'd24, 32'h7, 1'b1);
    wr(0, 32'd28, 32'h8, 1'b1);
    wr(1, 32'd44, 32'h9, 1'b1);
    wr(0, 32'd56, 32'hA, 1'b1);
    wr(1, 32'd60, 32'hB, 1'b1);
    #1;
    chk("tile2_nw", nw, 32);

    // Reset in the second DRAIN cycle
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'd0;
    #1;
    chk("drain_start2", acc_start, 1);
    chk("drain_gnt0", m0_gnt, 0);
    chk("drain_busy", busy, 1);
    @(negedge clk);
    chk("drain2_en_r", buf_en_r, 1);
    rstn = 1'b0;
    m0_req = 1'b0;
    @(negedge clk);
    chk("rstdrain_en_r", buf_en_r, 0);
    chk("rstdrain_busy", busy, 0);
    chk("rstdrain_start", acc_start, 0);
    rstn = 1'b1;

    // Counts were cleared: 15 writes must not start a drain, the 16th must
    fill(1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("partial_busy", busy, 0);
    end
    wr(1, 32'd60, 32'hC, 1'b1);
    check_drain(1'b1);
    #1;
    chk("tile3_ns", ns, 3);

`ifdef BUF_SCHED_TIMEOUT_EN
    repeat (7) @(negedge clk);
    chk("wd_before_busy", busy, 1);
    chk("wd_before_tmo", tmo_err, 0);
    @(negedge clk);
    chk("wd_after_busy", busy, 0);
    chk("wd_after_tmo", tmo_err, 1);
    fill(1'b0);
    chk("wd_tmo_sticky", tmo_err, 1);
    check_drain(1'b0);
    chk("wd_tmo_cleared", tmo_err, 0);
    #1;
    chk("tile4_ns", ns, 4);
`else
    repeat (20) @(negedge clk);
    chk("nowd_busy", busy, 1);
    chk("nowd_tmo", tmo_err, 0);
    m1_req = 1'b1; m1_addr = 32'd0; m1_data = 32'h77;
    #1;
    chk("nowd_gnt1", m1_gnt, 0);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    #1;
    chk("nowd_done_busy", busy, 0);
    chk("nowd_done_gnt1", m1_gnt, 1);
    @(negedge clk);
    m1_req = 1'b0;
    chk("nowd_en_w", buf_en_w, 1);
    chk("nowd_data", buf_data, 32'h77);
`endif

    #1;
    chk("no_w_r_overlap", ovl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
